tone_sequencer_voice: RTL and testbench

- Parametrised successor to the fixed-table square-wave note generator.
- Produces a phase-continuous square wave for any of 12 semitones across 4 octaves.
- Plays each note for a programmed duration in milliseconds, then pulses done.
- Accepts a one-deep pending note, applied glitch-free at the next half-period boundary (legato); sits between the song/keypad controller and the speaker pin.

---
 rtl/tone_sequencer_voice_pkg.sv | 21 ++
 rtl/tone_sequencer_voice_ms_tick_gen.sv | 28 ++
 rtl/tone_sequencer_voice.sv | 156 +++++++++++++++
 tb/tb_tone_sequencer_voice.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/tone_sequencer_voice_pkg.sv
// Shared constants for the tone sequencer voice: the note frequency table,
// the half-period helper and the voice state encoding.
package tone_pkg;

  localparam int unsigned NUM_NOTES = 12;
  localparam logic [3:0]  REST_MIN  = 4'd12;

  // C4..B4 in centi-Hz
  localparam int unsigned F_CHZ [NUM_NOTES] = '{
    26163, 27718, 29366, 31113, 32963, 34923,
    36999, 39200, 41530, 44000, 46616, 49388
  };

  typedef enum logic {IDLE, PLAY} state_t;

  // Half-period in clocks of semitone idx: clk_hz / (2 * f), f = F_CHZ/100
  function automatic logic [63:0] note_half(input logic [63:0] clk_hz, input int idx);
    return (clk_hz * 64'd50) / 64'(F_CHZ[idx]);
  endfunction

endpackage

// File: rtl/tone_sequencer_voice_ms_tick_gen.sv
// Millisecond strobe: one-cycle tick every CLK_HZ/1000 enabled cycles.
module ms_tick_gen
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned DIV = CLK_HZ / 1000;
  localparam int unsigned W   = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  // Not gated by clr: clr is derived from tick upstream, so gating would loop
  assign tick = en && (cnt == W'(DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      cnt <= '0;
    else if (clr)      cnt <= '0;
    else if (en)       cnt <= tick ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/tone_sequencer_voice.sv
// Square-wave note voice: 12 semitones x 4 octaves, timed in ms, with a
// one-deep pending note that takes over at the next half-period boundary.
module tone_sequencer_voice
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned CNT_W  = 21,
  parameter int unsigned DUR_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       note,
  input  logic [1:0]       octave,
  input  logic [DUR_W-1:0] dur_ms,
  input  logic             stop,
  input  logic             en,
  output logic             speaker,
  output logic             busy,
  output logic             done
);

  typedef struct packed {
    logic [3:0]       note;
    logic [1:0]       octave;
    logic [DUR_W-1:0] dur;
  } req_t;

  // Rest slots hold 0 so a rest loads half_q = 0 with no extra muxing
  logic [CNT_W-1:0] half_tbl [16];
  for (genvar i = 0; i < 16; i++) begin : g_tbl
    if (i < NUM_NOTES) begin : g_note
      assign half_tbl[i] = CNT_W'(note_half(64'(CLK_HZ), i));
    end else begin : g_rest
      assign half_tbl[i] = '0;
    end
  end

  state_t           state_q, state_d;
  req_t             req_in, pend_q, ld_req;
  logic             pend_vld;
  logic             rest_q;
  logic [CNT_W-1:0] half_q, div_cnt;
  logic [DUR_W-1:0] dur_q, ms_cnt;
  logic             phase;
  logic             play_st, boundary, tick, expire;
  logic             load, keep_phase, pend_set, pend_clr, done_d;
  logic             ld_rest;
  logic [CNT_W-1:0] ld_half;

  assign req_in   = {note, octave, dur_ms};
  assign play_st  = (state_q == PLAY);
  assign busy     = play_st | pend_vld;
  assign boundary = play_st && en && !rest_q && (div_cnt == half_q - CNT_W'(1));
  assign expire   = play_st && tick && (dur_q != '0) && (ms_cnt + DUR_W'(1) == dur_q);
  assign ld_rest  = (ld_req.note >= REST_MIN);
  assign ld_half  = half_tbl[ld_req.note] >> ld_req.octave;

  ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_ms_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (load),
    .en      (en && play_st),
    .tick    (tick)
  );

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    ld_req     = pend_q;
    keep_phase = 1'b0;
    pend_set   = 1'b0;
    pend_clr   = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          load    = 1'b1;
          ld_req  = req_in;
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (stop) begin
          state_d  = IDLE;
          pend_clr = 1'b1;
        end else if (expire) begin
          // A fresh start beats both the pending slot and the done pulse
          if (start) begin
            load     = 1'b1;
            ld_req   = req_in;
            pend_clr = 1'b1;
          end else if (pend_vld) begin
            load     = 1'b1;
            pend_clr = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          if (pend_vld && (rest_q || boundary)) begin
            load       = 1'b1;
            keep_phase = boundary;
            pend_clr   = 1'b1;
          end
          pend_set = start;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      pend_vld <= 1'b0;
      rest_q   <= 1'b0;
      half_q   <= '0;
      dur_q    <= '0;
      div_cnt  <= '0;
      ms_cnt   <= '0;
      phase    <= 1'b0;
      speaker  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
      speaker <= play_st && en && !stop && phase && !rest_q;
      if (pend_set) begin
        pend_q   <= req_in;
        pend_vld <= 1'b1;
      end else if (pend_clr) begin
        pend_vld <= 1'b0;
      end
      if (load) begin
        rest_q  <= ld_rest;
        half_q  <= ld_half;
        dur_q   <= ld_req.dur;
        div_cnt <= '0;
        ms_cnt  <= '0;
        // Legato swap keeps toggling; every other load restarts low
        phase   <= keep_phase && !ld_rest ? ~phase : 1'b0;
      end else if (play_st && en) begin
        if (tick) ms_cnt <= ms_cnt + DUR_W'(1);
        if (boundary) begin
          div_cnt <= '0;
          phase   <= ~phase;
        end else if (!rest_q) begin
          div_cnt <= div_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tone_sequencer_voice.sv
// Randomized and directed bench for tone_sequencer_voice at CLK_HZ = 1 MHz.
module tb_tone_sequencer_voice;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int          DUR_W  = 16;

  logic             clk = 1'b0, reset_n = 1'b0;
  logic             start = 1'b0, stop = 1'b0, en = 1'b1;
  logic [3:0]       note = '0;
  logic [1:0]       octave = '0;
  logic [DUR_W-1:0] dur_ms = '0;
  logic             speaker, busy, done;

  int checks = 0, errors = 0;

  tone_sequencer_voice #(.CLK_HZ(CLK_HZ), .CNT_W(21), .DUR_W(DUR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .note    (note),
    .octave  (octave),
    .dur_ms  (dur_ms),
    .stop    (stop),
    .en      (en),
    .speaker (speaker),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: half-period = CLK_HZ / (2 * f_Hz) >> octave, 0 for rests
  int unsigned freq_chz [12] = '{26163, 27718, 29366, 31113, 32963, 34923,
                                 36999, 39200, 41530, 44000, 46616, 49388};
  function automatic int ref_half(input int n, input int o);
    if (n >= 12) return 0;
    return int'((CLK_HZ * 50) / freq_chz[n]) >>> o;
  endfunction

  int m_done_t, m_rise, m_wmin, m_wmax, m_ntr, m_nhigh, m_busy0, m_busy_done, m_done_after;
  int trq[$];

  // t = 0 is the first negedge after the load edge
  task automatic play(input int n, input int o, input int d, input int p_at, input int p_len);
    logic prev;
    int   last, w;
    @(negedge clk); note = 4'(n); octave = 2'(o); dur_ms = DUR_W'(d); start = 1'b1;
    @(negedge clk); start = 1'b0;
    m_done_t = -1; m_rise = -1; m_wmin = -1; m_wmax = -1; m_ntr = 0; m_nhigh = 0;
    m_busy0 = busy; m_busy_done = -1; last = -1; prev = 1'b0;
    for (int t = 0; t < 12000; t++) begin
      if (t > 0) @(negedge clk);
      if (t == p_at) en = 1'b0;
      if (p_len > 0 && t == p_at + p_len) en = 1'b1;
      if (speaker) m_nhigh++;
      if (speaker !== prev) begin
        m_ntr++;
        if (speaker && m_rise < 0) m_rise = t;
        if (last >= 0) begin
          w = t - last;
          if (m_wmin < 0 || w < m_wmin) m_wmin = w;
          if (w > m_wmax) m_wmax = w;
        end
        last = t; prev = speaker;
      end
      if (done) begin
        m_done_t = t; m_busy_done = busy;
        break;
      end
    end
    en = 1'b1;
    @(negedge clk); m_done_after = done;
  endtask

  task automatic check_play(input string tag, input int n, input int o, input int d,
                            input int p_at, input int p_len);
    int h, dt, ntr;
    play(n, o, d, p_at, p_len);
    h  = ref_half(n, o);
    dt = d * 1000 + p_len;
    chk({tag, ".busy0"}, m_busy0, 1);
    chk({tag, ".done_t"}, m_done_t, dt);
    chk({tag, ".busy_at_done"}, m_busy_done, 0);
    chk({tag, ".done_width"}, m_done_after, 0);
    if (p_len == 0) begin
      if (h == 0) chk({tag, ".rest_high"}, m_nhigh, 0);
      else begin
        ntr = (dt - 1) / h;
        chk({tag, ".ntr"}, m_ntr, ntr);
        chk({tag, ".rise"}, m_rise, (ntr >= 1) ? h + 1 : -1);
        if (ntr >= 2) begin
          chk({tag, ".wmin"}, m_wmin, h);
          chk({tag, ".wmax"}, m_wmax, h);
        end
      end
    end
  endtask

  initial begin
    int nd, first_done;
    logic prev;
    int exp_tr [4];

    repeat (3) @(negedge clk);
    chk("rst.speaker", speaker, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    reset_n = 1'b1;
    @(negedge clk);

    check_play("a4_3ms", 9, 0, 3, -1, 0);
    check_play("a6", 9, 2, 1, -1, 0);
    check_play("c4", 0, 0, 4, -1, 0);
    check_play("rest", 12, 0, 2, -1, 0);
    check_play("pause", 9, 0, 3, 700, 500);

    for (int i = 0; i < 8; i++) begin
      int n, o, d, pa, pl;
      n = int'($urandom_range(0, 15));
      o = int'($urandom_range(0, 3));
      d = int'($urandom_range(1, 3));
      if ($urandom_range(0, 2) == 0) begin
        pa = int'($urandom_range(100, 800)); pl = int'($urandom_range(1, 500));
      end else begin
        pa = -1; pl = 0;
      end
      check_play($sformatf("rnd%0d", i), n, o, d, pa, pl);
    end

    // Legato: A4 sustained, B4 requested mid-high half, swap at next toggle
    exp_tr = '{1137, 2273, 3285, 4297};
    @(negedge clk); note = 4'd9; octave = 2'd0; dur_ms = '0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    trq.delete(); prev = 1'b0; nd = 0;
    for (int t = 0; t < 4420; t++) begin
      if (t > 0) @(negedge clk);
      if (t == 1500) begin note = 4'd11; start = 1'b1; end
      if (t == 1501) begin start = 1'b0; chk("leg.busy_pend", busy, 1); end
      if (speaker !== prev) begin trq.push_back(t); prev = speaker; end
      if (done) nd++;
    end
    chk("leg.ntr", trq.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("leg.tr%0d", i), (i < trq.size()) ? trq[i] : -1, exp_tr[i]);
    chk("leg.no_done", nd, 0);

    // Stop with a pending note queued
    @(negedge clk); note = 4'd2; start = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("stop.busy", busy, 0);
    chk("stop.speaker", speaker, 0);
    nd = 0;
    repeat (20) begin @(negedge clk); if (done || speaker) nd++; end
    chk("stop.quiet", nd, 0);

    // start and stop together from IDLE: stop wins
    @(negedge clk); note = 4'd4; dur_ms = DUR_W'(1); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    chk("startstop.busy", busy, 0);

    // Start coincident with expiry: no done, new 1 ms counted from that edge
    @(negedge clk); note = 4'd9; dur_ms = DUR_W'(1); start = 1'b1;
    @(negedge clk); start = 1'b0;
    first_done = -1;
    for (int t = 0; t < 2500; t++) begin
      if (t > 0) @(negedge clk);
      if (t == 999) begin note = 4'd0; dur_ms = DUR_W'(1); start = 1'b1; end
      if (t == 1000) begin start = 1'b0; chk("col.busy", busy, 1); end
      if (done && first_done < 0) first_done = t;
    end
    chk("col.done_t", first_done, 2000);

    // Async reset mid-note, away from any clock edge
    @(negedge clk); note = 4'd9; dur_ms = '0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (1200) @(negedge clk);
    chk("ar.pre_speaker", speaker, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar.speaker", speaker, 0);
    chk("ar.busy", busy, 0);
    chk("ar.done", done, 0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
